// File: rtl/bcd_div_stream.sv
// Streaming BCD divisibility checker: folds MSD-first BCD digits into a running
// remainder modulo DIVISOR and reports remainder, divisibility and BCD error once per operand.
module bcd_div_stream #(
    parameter int DIGITS  = 4,
    parameter int DIVISOR = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic       digit_ready,
    output logic       busy,
    output logic       done,
    output logic       divisible,
    output logic [3:0] remainder,
    output logic       bcd_err
);

    // state  | meaning
    // IDLE   | waiting for start, results held
    // ACCUM  | accepting digits, remainder accumulating
    // REPORT | one-cycle done pulse, then back to IDLE

    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [3:0]       rem_acc;
    logic             err;

    logic             start_acc;
    logic             accept;
    logic             last_accept;
    logic [7:0]       rem_sum;
    logic [3:0]       rem_mod;
    logic [3:0]       rem_new;
    logic             err_new;

    logic             digit_ready_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    assign start_acc   = start && ((state == IDLE) || (state == ACCUM));
    assign accept      = (state == ACCUM) && digit_valid && !start;
    assign last_accept = accept && (count == CNT_W'(DIGITS - 1));

    // Worst case 14*10+9 = 149, so 8 bits hold the sum before reduction.
    assign rem_sum = ({4'd0, rem_acc} * 8'd10) + {4'd0, digit};
    assign rem_mod = 4'(rem_sum % 8'(DIVISOR));

    always_comb begin
        rem_new = rem_acc;
        err_new = err;
        if (digit > 4'd9) begin
            err_new = 1'b1;
        end else begin
            rem_new = rem_mod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_accept) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded from next state so the flag registers line up with the state register.
    always_comb begin
        digit_ready_nxt = 1'b0;
        busy_nxt        = 1'b0;
        done_nxt        = 1'b0;
        case (state_next)
            ACCUM: begin
                digit_ready_nxt = 1'b1;
                busy_nxt        = 1'b1;
            end
            REPORT: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            digit_ready <= digit_ready_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            rem_acc <= 4'd0;
            err     <= 1'b0;
        end else if (start_acc) begin
            count   <= '0;
            rem_acc <= 4'd0;
            err     <= 1'b0;
        end else if (accept) begin
            count   <= count + 1'b1;
            rem_acc <= rem_new;
            err     <= err_new;
        end
    end

    // Results load with the final digit so they are valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisible <= 1'b0;
            remainder <= 4'd0;
            bcd_err   <= 1'b0;
        end else if (start_acc) begin
            divisible <= 1'b0;
            remainder <= 4'd0;
            bcd_err   <= 1'b0;
        end else if (last_accept) begin
            divisible <= (rem_new == 4'd0) && !err_new;
            remainder <= rem_new;
            bcd_err   <= err_new;
        end
    end

endmodule

// File: tb/tb_bcd_div_stream.sv
// Self-checking bench for bcd_div_stream: directed and random operands against an
// integer-value reference model, on divisor 3, divisor 7 and single-digit instances.
module tb_bcd_div_stream;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       digit_valid;
    logic [3:0] digit;
    logic       s_start;
    logic       s_valid;
    logic [3:0] s_digit;

    logic       ready_a, busy_a, done_a, div_a, err_a;
    logic [3:0] rem_a;
    logic       ready_b, busy_b, done_b, div_b, err_b;
    logic [3:0] rem_b;
    logic       ready_c, busy_c, done_c, div_c, err_c;
    logic [3:0] rem_c;

    int n_cmp = 0;
    int n_err = 0;
    int n_done_a = 0;
    int n_done_b = 0;
    int exp_done = 0;

    longint unsigned m_val;
    bit              m_err;

    bcd_div_stream dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid), .digit(digit),
        .digit_ready(ready_a), .busy(busy_a), .done(done_a), .divisible(div_a),
        .remainder(rem_a), .bcd_err(err_a)
    );

    bcd_div_stream #(.DIGITS(4), .DIVISOR(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid), .digit(digit),
        .digit_ready(ready_b), .busy(busy_b), .done(done_b), .divisible(div_b),
        .remainder(rem_b), .bcd_err(err_b)
    );

    bcd_div_stream #(.DIGITS(1), .DIVISOR(5)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(s_start), .digit_valid(s_valid), .digit(s_digit),
        .digit_ready(ready_c), .busy(busy_c), .done(done_c), .divisible(div_c),
        .remainder(rem_c), .bcd_err(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_a === 1'b1) n_done_a++;
        if (done_b === 1'b1) n_done_b++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_op();
        start       = 1'b1;
        digit_valid = 1'b0;
        tick();
        start = 1'b0;
        m_val = 0;
        m_err = 1'b0;
        chk("start_ready_a", ready_a, 1'b1);
        chk("start_busy_b", busy_b, 1'b1);
        chk("start_clr_rem_a", rem_a, 4'd0);
        chk("start_clr_div_b", div_b, 1'b0);
        chk("start_clr_err_a", err_a, 1'b0);
    endtask

    task automatic feed(input logic [3:0] d, input int gaps);
        digit_valid = 1'b0;
        repeat (gaps) begin
            digit = 4'($urandom_range(0, 15));
            tick();
        end
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
        if (d <= 4'd9) m_val = m_val * 10 + longint'(d);
        else m_err = 1'b1;
    endtask

    task automatic check_mid(input string tag);
        chk({tag, "_done_a"}, done_a, 1'b0);
        chk({tag, "_ready_b"}, ready_b, 1'b1);
    endtask

    task automatic finish_check(input bit start_in_report);
        logic [3:0] er_a;
        logic [3:0] er_b;
        er_a = 4'(m_val % 3);
        er_b = 4'(m_val % 7);
        exp_done++;
        if (start_in_report) start = 1'b1;
        chk("rep_done_a", done_a, 1'b1);
        chk("rep_done_b", done_b, 1'b1);
        chk("rep_busy_a", busy_a, 1'b1);
        chk("rep_ready_a", ready_a, 1'b0);
        chk("rep_rem_a", rem_a, er_a);
        chk("rep_rem_b", rem_b, er_b);
        chk("rep_div_a", div_a, (er_a == 0) && !m_err);
        chk("rep_div_b", div_b, (er_b == 0) && !m_err);
        chk("rep_err_a", err_a, m_err);
        chk("rep_err_b", err_b, m_err);
        tick();
        start = 1'b0;
        chk("idle_done_a", done_a, 1'b0);
        chk("idle_busy_a", busy_a, 1'b0);
        chk("idle_ready_b", ready_b, 1'b0);
        chk("hold_rem_a", rem_a, er_a);
        chk("hold_rem_b", rem_b, er_b);
        chk("hold_div_a", div_a, (er_a == 0) && !m_err);
        chk("done_count_a", n_done_a, exp_done);
        chk("done_count_b", n_done_b, exp_done);
    endtask

    initial begin
        logic [3:0] ops [4];
        logic [3:0] dc  [3];
        logic [3:0] d;

        rst_n = 1'b0; start = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        s_start = 1'b0; s_valid = 1'b0; s_digit = 4'd0;
        m_val = 0; m_err = 1'b0;
        tick(); tick();
        chk("rst_ready_a", ready_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_done_b", done_b, 1'b0);
        chk("rst_rem_a", rem_a, 4'd0);
        chk("rst_div_a", div_a, 1'b0);
        chk("rst_err_b", err_b, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("idle_ready_wait", ready_a, 1'b0);

        // 1234: contiguous, with start held during REPORT
        begin_op();
        ops = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 4; i++) begin
            feed(ops[i], 0);
            if (i < 3) check_mid("c1234");
        end
        finish_check(1'b1);
        chk("report_start_ignored", busy_a, 1'b0);

        // 0369 with valid low on alternate cycles
        begin_op();
        ops = '{4'd0, 4'd3, 4'd6, 4'd9};
        for (int i = 0; i < 4; i++) feed(ops[i], 1);
        finish_check(1'b0);

        // 0154 then 0155 back to back
        begin_op();
        ops = '{4'd0, 4'd1, 4'd5, 4'd4};
        for (int i = 0; i < 4; i++) feed(ops[i], 0);
        finish_check(1'b0);
        begin_op();
        ops = '{4'd0, 4'd1, 4'd5, 4'd5};
        for (int i = 0; i < 4; i++) feed(ops[i], 0);
        finish_check(1'b0);

        // 1,A,2,0: error flag, remainder from the valid digits only
        begin_op();
        ops = '{4'd1, 4'hA, 4'd2, 4'd0};
        for (int i = 0; i < 4; i++) feed(ops[i], 0);
        finish_check(1'b0);

        // abort after 7,7; the digit presented with the abort start is dropped
        begin_op();
        feed(4'd7, 0);
        feed(4'd7, 0);
        start = 1'b1; digit_valid = 1'b1; digit = 4'd5;
        tick();
        start = 1'b0; digit_valid = 1'b0;
        m_val = 0; m_err = 1'b0;
        chk("abort_ready_a", ready_a, 1'b1);
        chk("abort_no_done", n_done_a, exp_done);
        ops = '{4'd0, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 4; i++) feed(ops[i], 0);
        finish_check(1'b0);

        // reset mid-operand
        begin_op();
        feed(4'd4, 0);
        feed(4'd2, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready_a", ready_a, 1'b0);
        chk("arst_busy_a", busy_a, 1'b0);
        chk("arst_busy_b", busy_b, 1'b0);
        chk("arst_done_a", done_a, 1'b0);
        chk("arst_rem_a", rem_a, 4'd0);
        @(negedge clk) rst_n = 1'b1;
        feed(4'd3, 0);
        tick(); tick();
        chk("arst_wait_start", busy_a, 1'b0);
        chk("arst_no_done", n_done_a, exp_done);
        begin_op();
        for (int i = 0; i < 4; i++) feed(4'd9, 0);
        finish_check(1'b0);

        // random operands, random gaps, occasional non-BCD digits
        for (int k = 0; k < 25; k++) begin
            begin_op();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(10, 15));
                else d = 4'($urandom_range(0, 9));
                feed(d, int'($urandom_range(0, 2)));
            end
            finish_check(1'($urandom_range(0, 1)));
        end

        // single-digit operand instance
        dc = '{4'd7, 4'd5, 4'd12};
        for (int i = 0; i < 3; i++) begin
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            chk("c_ready", ready_c, 1'b1);
            s_valid = 1'b1;
            s_digit = dc[i];
            tick();
            s_valid = 1'b0;
            chk("c_done", done_c, 1'b1);
            chk("c_rem", rem_c, (dc[i] <= 4'd9) ? 4'(dc[i] % 5) : 4'd0);
            chk("c_div", div_c, (dc[i] <= 4'd9) && (dc[i] % 5 == 0));
            chk("c_err", err_c, dc[i] > 4'd9);
            tick();
            chk("c_done_off", done_c, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
